serial_slave_port: RTL and testbench

Responder end of the serial master/slave bus. One instance sits behind each slave port of the bus arbiter. It deserialises the address and write data that a master drives through the arbiter, and services writes into a local memory. Reads return data serially, and the port raises `hold` during the memory access so the arbiter may split the transaction and grant the bus to the other master.

---
 rtl/serial_slave_port.sv | 158 +++++++++++++++
 tb/tb_serial_slave_port.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_slave_port.sv
// serial_slave_port: serial bus responder that deserialises address/write data,
// services writes into a local memory and returns read data serially.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-low reset
//   address    in   serial address bit, LSB first
//   data       in   serial write-data bit, LSB first
//   valid      in   qualifies address/data this cycle
//   write_en   in   1 = write, 0 = read; sampled with the first address bit
//   bus_ready  in   shared return path is free
//   data_out   out  serial read-data bit, LSB first
//   valid_out  out  qualifies data_out
//   ready      out  idle and able to accept a new transaction
//   hold       out  split request while the read access is in progress
module serial_slave_port #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 4,
    parameter bit SPLIT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic address,
    input  logic data,
    input  logic valid,
    input  logic write_en,
    input  logic bus_ready,
    output logic data_out,
    output logic valid_out,
    output logic ready,
    output logic hold
);
    localparam int MAX_AD = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAXV   = MAX_AD > READ_LATENCY ? MAX_AD : READ_LATENCY;
    // one spare code above READ_LATENCY marks "word loaded, waiting for bus"
    localparam int CW     = $clog2(MAXV + 2);
    localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAT    = CW'(READ_LATENCY);

    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, WRITE, READ_WAIT, TX_DATA} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [ADDR_WIDTH-1:0]   addr, addr_n, addr_sh;
    logic [DATA_WIDTH-1:0]   wdata, wdata_n, wdata_sh;
    logic [DATA_WIDTH-1:0]   shift, shift_n, src;
    logic                    is_write, is_write_n;
    logic                    data_out_n, valid_out_n, ready_n, hold_n;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    // LSB-first shift: new bit enters at the top and walks down
    assign addr_sh  = (addr >> 1) | (ADDR_WIDTH'(address) << (ADDR_WIDTH - 1));
    assign wdata_sh = (wdata >> 1) | (DATA_WIDTH'(data) << (DATA_WIDTH - 1));
    // on the expiry cycle the word comes straight from memory, afterwards from the shifter
    assign src      = (cnt == LAT) ? mem[addr] : shift;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        addr_n      = addr;
        wdata_n     = wdata;
        shift_n     = shift;
        is_write_n  = is_write;
        data_out_n  = data_out;
        valid_out_n = 1'b0;
        ready_n     = 1'b0;
        hold_n      = 1'b0;
        case (state)
            IDLE: begin
                data_out_n = 1'b0;
                ready_n    = 1'b1;
                if (valid && ready) begin
                    addr_n     = addr_sh;
                    is_write_n = write_en;
                    ready_n    = 1'b0;
                    state_n    = ADDR_WIDTH == 1 ? (write_en ? RX_DATA : READ_WAIT) : RX_ADDR;
                    cnt_n      = ADDR_WIDTH == 1 ? '0 : CW'(1);
                end
            end
            RX_ADDR: begin
                if (valid) begin
                    addr_n  = addr_sh;
                    state_n = cnt == A_LAST ? (is_write ? RX_DATA : READ_WAIT) : RX_ADDR;
                    cnt_n   = cnt == A_LAST ? '0 : cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (valid) begin
                    wdata_n = wdata_sh;
                    state_n = cnt == D_LAST ? WRITE : RX_DATA;
                    cnt_n   = cnt == D_LAST ? '0 : cnt + CW'(1);
                end
            end
            WRITE: begin
                state_n = IDLE;
            end
            READ_WAIT: begin
                if (cnt < LAT) begin
                    hold_n = SPLIT_EN;
                    cnt_n  = cnt + CW'(1);
                end else if (bus_ready) begin
                    // first bit leaves on the same edge the access completes
                    data_out_n  = src[0];
                    valid_out_n = 1'b1;
                    shift_n     = src >> 1;
                    state_n     = DATA_WIDTH == 1 ? IDLE : TX_DATA;
                    cnt_n       = CW'(1);
                end else begin
                    shift_n = src;
                    cnt_n   = LAT + CW'(1);
                end
            end
            TX_DATA: begin
                if (bus_ready) begin
                    data_out_n  = shift[0];
                    valid_out_n = 1'b1;
                    shift_n     = shift >> 1;
                    state_n     = cnt == D_LAST ? IDLE : TX_DATA;
                    cnt_n       = cnt == D_LAST ? '0 : cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr      <= '0;
            wdata     <= '0;
            shift     <= '0;
            is_write  <= 1'b0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
            ready     <= 1'b1;
            hold      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            shift     <= shift_n;
            is_write  <= is_write_n;
            data_out  <= data_out_n;
            valid_out <= valid_out_n;
            ready     <= ready_n;
            hold      <= hold_n;
        end
    end

    // memory is not reset; a reset during WRITE suppresses the store
    always_ff @(posedge clk) begin
        if (reset && state == WRITE) mem[addr] <= wdata;
    end
endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: scoreboard bench for serial_slave_port (default and no-split instances).
module tb_serial_slave_port;
    logic clk = 1'b0;
    logic reset, address, data, valid, write_en, bus_ready, sel;
    logic dout0, vo0, rdy0, hold0, dout1, vo1, rdy1, hold1;
    logic dout_m, vo_m, rdy_m, hold_m;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    typedef struct {logic [7:0] d; int h; int s;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_slave_port u0 (
        .clk(clk), .reset(reset), .address(address), .data(data), .valid(valid & ~sel),
        .write_en(write_en), .bus_ready(bus_ready), .data_out(dout0), .valid_out(vo0),
        .ready(rdy0), .hold(hold0)
    );

    serial_slave_port #(.SPLIT_EN(1'b0), .READ_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .address(address), .data(data), .valid(valid & sel),
        .write_en(write_en), .bus_ready(bus_ready), .data_out(dout1), .valid_out(vo1),
        .ready(rdy1), .hold(hold1)
    );

    assign dout_m = sel ? dout1 : dout0;
    assign vo_m   = sel ? vo1   : vo0;
    assign rdy_m  = sel ? rdy1  : rdy0;
    assign hold_m = sel ? hold1 : hold0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // monitor: assemble each served word and compare it against the scoreboard
    logic [7:0] word;
    int nb = 0, hc = 0, st = 0;
    always @(negedge clk) begin
        if (!reset) begin
            nb = 0; hc = 0; st = 0;
        end else begin
            if (hold_m) hc++;
            if (vo_m) begin
                word[nb[2:0]] = dout_m;
                nb++;
                if (nb == 8) begin
                    if (q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_word got=%0h", word);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("read_data", int'(word), int'(e.d));
                        chk("hold_cycles", hc, e.h);
                        chk("tx_stalls", st, e.s);
                    end
                    nb = 0; hc = 0; st = 0;
                end
            end else if (nb > 0) st++;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!rdy_m && n < 200) begin @(posedge clk); #1; n++; end
        if (!rdy_m) chk("ready_timeout", 0, 1);
    endtask

    // ag/dg: bit i set = one valid=0 stall cycle before bit i; nd = data bits sent
    task automatic txn(input logic we, input logic [11:0] a, input logic [7:0] d,
                       input logic [11:0] ag, input logic [7:0] dg, input int nd);
        for (int i = 0; i < 12; i++) begin
            if (ag[i]) begin valid = 1'b0; @(posedge clk); #1; end
            valid = 1'b1; address = a[i]; write_en = we;
            @(posedge clk); #1;
        end
        if (we) for (int i = 0; i < nd; i++) begin
            if (dg[i]) begin valid = 1'b0; @(posedge clk); #1; end
            valid = 1'b1; data = d[i];
            @(posedge clk); #1;
        end
        valid = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d, input logic [11:0] ag,
                      input logic [7:0] dg, output int cycles);
        int t0;
        wait_ready();
        t0 = cyc;
        txn(1'b1, a, d, ag, dg, 8);
        wait_ready();
        cycles = cyc - t0;
    endtask

    // pre: bus_ready low cycles once the access expires; mid_len low cycles after bit mid_at
    task automatic rd(input logic [11:0] a, input logic [7:0] d, input int lat, input int hexp,
                      input int pre, input int mid_at, input int mid_len);
        int first = -1;
        int s0 = lat + 1 + pre;
        wait_ready();
        q.push_back('{d, hexp, mid_len});
        txn(1'b0, a, 8'h00, 12'h0, 8'h0, 0);
        for (int k = 1; k <= s0 + 8 + mid_len; k++) begin
            bus_ready = !((k > lat && k <= lat + pre) || (k > s0 + mid_at && k <= s0 + mid_at + mid_len));
            @(posedge clk); #1;
            if (vo_m && first < 0) first = k;
        end
        bus_ready = 1'b1;
        chk("first_valid_out", first, s0);
        chk("ready_after_read", int'(rdy_m), 1);
    endtask

    initial begin
        int c0, c1;
        reset = 1'b0; address = 1'b0; data = 1'b0; valid = 1'b0;
        write_en = 1'b0; bus_ready = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", int'(rdy0), 1);  chk("rst_dout0", int'(dout0), 0);
        chk("rst_vo0", int'(vo0), 0);      chk("rst_hold0", int'(hold0), 0);
        chk("rst_ready1", int'(rdy1), 1);  chk("rst_dout1", int'(dout1), 0);
        chk("rst_vo1", int'(vo1), 0);      chk("rst_hold1", int'(hold1), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // basic write then read
        wr(12'h123, 8'hA5, 12'h0, 8'h0, c0);
        chk("write_cycles", c0, 22);
        rd(12'h123, 8'hA5, 4, 4, 0, 0, 0);

        // stalls on valid add exactly one cycle each
        wr(12'h045, 8'h3C, 12'h0, 8'h0, c0);
        wr(12'h045, 8'h3C, 12'h488, 8'h24, c1);
        chk("gap_write_cycles", c1, 27);
        chk("gap_delta", c1 - c0, 5);
        rd(12'h045, 8'h3C, 4, 4, 0, 0, 0);

        // bus_ready stalls before and during the serial word
        rd(12'h123, 8'hA5, 4, 4, 5, 3, 2);

        // boundary addresses
        wr(12'hFFF, 8'h11, 12'h0, 8'h0, c0);
        wr(12'h000, 8'h22, 12'h0, 8'h0, c0);
        rd(12'hFFF, 8'h11, 4, 4, 0, 0, 0);
        rd(12'h000, 8'h22, 4, 4, 0, 0, 0);

        // reset abort during RX_DATA leaves memory untouched
        wr(12'h010, 8'h55, 12'h0, 8'h0, c0);
        wait_ready();
        txn(1'b1, 12'h010, 8'h77, 12'h0, 8'h0, 3);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", int'(rdy0), 1);  chk("abort_dout", int'(dout0), 0);
        chk("abort_vo", int'(vo0), 0);      chk("abort_hold", int'(hold0), 0);
        reset = 1'b1;
        rd(12'h010, 8'h55, 4, 4, 0, 0, 0);

        // no-split instance with single-cycle access
        sel = 1'b1;
        @(posedge clk); #1;
        wr(12'h3C3, 8'h5A, 12'h0, 8'h0, c0);
        rd(12'h3C3, 8'h5A, 1, 0, 0, 0, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
